// File: rtl/mem_wb.sv
// MEM/WB pipeline register: carries the register write-back triple into WB,
// owns the LLbit used by ll/sc, forwards it back to MEM and counts retirements.
module mem_wb (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_mem,
   input  logic        stall_wb,
   input  logic        flush,
   input  logic        mem_valid,
   input  logic [31:0] regData,
   input  logic [4:0]  regAddr,
   input  logic        regWrite,
   input  logic        wbit,
   input  logic        wLLbit,
   output logic [31:0] wb_regData,
   output logic [4:0]  wb_regAddr,
   output logic        wb_regWrite,
   output logic        rLLbit,
   output logic [31:0] retired
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic              llwe;
      logic              llval;
   } wb_entry_t;

   wb_entry_t pipe_q;
   wb_entry_t pipe_nxt;
   wb_entry_t cap;
   logic      llbit_q;
   logic      llbit_nxt;
   logic      count_en;

   // Bubbles never write the register file nor the LLbit.
   always_comb begin
      cap       = '0;
      cap.data  = regData;
      cap.addr  = regAddr;
      cap.we    = regWrite & mem_valid;
      cap.llwe  = wbit & mem_valid;
      cap.llval = wLLbit;
   end

   // Pipeline entry: flush > MEM-only stall (bubble) > any WB stall (hold) > capture.
   always_comb begin
      pipe_nxt = cap;
      if (flush) begin
         pipe_nxt = '0;
      end else if (stall_mem && !stall_wb) begin
         pipe_nxt = '0;
      end else if (stall_wb) begin
         pipe_nxt = pipe_q;
      end
   end

   // A pending LLbit write commits only when WB advances, so a held entry commits once.
   always_comb begin
      llbit_nxt = llbit_q;
      if (flush) begin
         llbit_nxt = 1'b0;
      end else if (pipe_q.llwe && !stall_wb) begin
         llbit_nxt = pipe_q.llval;
      end
   end

   assign count_en = !flush && !stall_mem && !stall_wb && mem_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_q  <= '0;
         llbit_q <= 1'b0;
         retired <= '0;
      end else begin
         pipe_q  <= pipe_nxt;
         llbit_q <= llbit_nxt;
         if (count_en) begin
            retired <= retired + DATA_W'(1);
         end
      end
   end

   assign wb_regData  = pipe_q.data;
   assign wb_regAddr  = pipe_q.addr;
   assign wb_regWrite = pipe_q.we;

   // Forward the in-flight LLbit write so back-to-back ll; sc sees it.
   assign rLLbit = flush ? 1'b0 : (pipe_q.llwe ? pipe_q.llval : llbit_q);

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: reset, ll/sc forwarding, flush, stalls,
// bubble qualification and retired-counter wrap.
module tb_mem_wb;

   logic        clk = 1'b0;
   logic        rst, stall_mem, stall_wb, flush, mem_valid;
   logic [31:0] regData;
   logic [4:0]  regAddr;
   logic        regWrite, wbit, wLLbit;
   logic [31:0] wb_regData;
   logic [4:0]  wb_regAddr;
   logic        wb_regWrite, rLLbit;
   logic [31:0] retired;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_wb dut (
      .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb),
      .flush(flush), .mem_valid(mem_valid), .regData(regData),
      .regAddr(regAddr), .regWrite(regWrite), .wbit(wbit), .wLLbit(wLLbit),
      .wb_regData(wb_regData), .wb_regAddr(wb_regAddr),
      .wb_regWrite(wb_regWrite), .rLLbit(rLLbit), .retired(retired)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a,
                        input logic we, input logic wb, input logic llv);
      mem_valid = v; regData = d; regAddr = a; regWrite = we; wbit = wb; wLLbit = llv;
   endtask

   initial begin
      rst = 1'b1; stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
      drive(1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

      // Reset with random inputs
      for (int i = 0; i < 2; i++) begin
         drive(1'($urandom), $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         stall_mem = 1'($urandom); stall_wb = 1'($urandom);
         tick();
      end
      stall_mem = 1'b0; stall_wb = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("rst_data", wb_regData, 32'h0);
      chk("rst_addr", 32'(wb_regAddr), 32'd0);
      chk("rst_we", 32'(wb_regWrite), 32'd0);
      chk("rst_llbit", 32'(rLLbit), 32'd0);
      chk("rst_retired", retired, 32'd0);

      // First capture after reset
      rst = 1'b0;
      drive(1'b1, 32'h12345678, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      chk("cap_data", wb_regData, 32'h12345678);
      chk("cap_addr", 32'(wb_regAddr), 32'd5);
      chk("cap_we", 32'(wb_regWrite), 32'd1);
      chk("cap_retired", retired, 32'd1);

      // ll then sc: sc sees forwarded LLbit
      drive(1'b1, 32'h0000_1000, 5'd8, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b1, 32'h0000_0001, 5'd9, 1'b1, 1'b1, 1'b0);
      #1;
      chk("ll_fwd", 32'(rLLbit), 32'd1);
      tick();
      chk("sc_fwd0", 32'(rLLbit), 32'd0);
      chk("sc_retired", retired, 32'd3);

      // Re-establish llbit=1 through the committed path
      drive(1'b1, 32'h0000_2000, 5'd10, 1'b0, 1'b1, 1'b1);
      tick();
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("llbit_set", 32'(rLLbit), 32'd1);
      chk("llbit_retired", retired, 32'd4);

      // Flush with an ll in MEM
      flush = 1'b1;
      drive(1'b1, 32'hDEAD_BEEF, 5'd11, 1'b1, 1'b1, 1'b1);
      #1;
      chk("flush_fwd", 32'(rLLbit), 32'd0);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("flush_we", 32'(wb_regWrite), 32'd0);
      chk("flush_llbit", 32'(rLLbit), 32'd0);
      chk("flush_retired", retired, 32'd4);

      // MEM-only stall inserts a bubble
      drive(1'b1, 32'h0000_AAAA, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
      chk("pre_stall_we", 32'(wb_regWrite), 32'd1);
      stall_mem = 1'b1;
      drive(1'b1, 32'h0000_BBBB, 5'd4, 1'b1, 1'b0, 1'b0);
      tick();
      chk("bub_we", 32'(wb_regWrite), 32'd0);
      chk("bub_data", wb_regData, 32'h0);
      chk("bub_retired", retired, 32'd5);

      // Both stalls hold a pending ll entry for three cycles
      stall_mem = 1'b0;
      drive(1'b1, 32'h0000_0055, 5'd7, 1'b1, 1'b1, 1'b1);
      tick();
      stall_mem = 1'b1; stall_wb = 1'b1;
      drive(1'b1, 32'h0000_0099, 5'd2, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_data", wb_regData, 32'h0000_0055);
         chk("hold_addr", 32'(wb_regAddr), 32'd7);
         chk("hold_retired", retired, 32'd6);
      end
      stall_mem = 1'b0; stall_wb = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("rel_llbit", 32'(rLLbit), 32'd1);
      chk("rel_we", 32'(wb_regWrite), 32'd0);
      chk("rel_retired", retired, 32'd6);

      // Bubble qualification: invalid MEM slot writes nothing
      drive(1'b0, 32'h0000_7777, 5'd12, 1'b1, 1'b1, 1'b0);
      tick();
      chk("q_we", 32'(wb_regWrite), 32'd0);
      chk("q_llbit", 32'(rLLbit), 32'd1);
      tick();
      chk("q_llbit2", 32'(rLLbit), 32'd1);
      chk("q_retired", retired, 32'd6);

      // Counter wrap
      force dut.retired = 32'hFFFF_FFFF;
      #1;
      release dut.retired;
      drive(1'b1, 32'h0000_0001, 5'd1, 1'b1, 1'b0, 1'b0);
      tick();
      chk("wrap", retired, 32'h0);

      // Reset mid-stall with a pending ll write
      drive(1'b1, 32'h0000_00CC, 5'd6, 1'b1, 1'b1, 1'b1);
      tick();
      stall_mem = 1'b1; stall_wb = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("mrst_data", wb_regData, 32'h0);
      chk("mrst_we", 32'(wb_regWrite), 32'd0);
      chk("mrst_llbit", 32'(rLLbit), 32'd0);
      tick();
      chk("mrst_llbit2", 32'(rLLbit), 32'd0);
      chk("mrst_retired", retired, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_wb.md
# mem_wb

Pipeline register between the MEM stage and the write-back stage of the five-stage MIPS core. Captures MEM's register write-back triple and LLbit update request, owns the architectural LLbit register used by `ll`/`sc`, and returns a forwarded LLbit value to MEM. Also applies stall and flush control from the pipeline controller and keeps a retired-instruction counter.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 5-bit register address.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high (`RST_ENABLE` = 1); sampled on rising edge of clk.
- stall_mem  in  1  MEM stage stalled this cycle.
- stall_wb  in  1  WB stage stalled this cycle.
- flush  in  1  exception/eret flush; discards MEM's result and clears LLbit.
- mem_valid  in  1  MEM holds a real instruction (0 = bubble).
- regData  in  32  MEM result data.
- regAddr  in  5  MEM destination register.
- regWrite  in  1  MEM register write enable.
- wbit  in  1  MEM requests an LLbit write.
- wLLbit  in  1  LLbit value to write.
- wb_regData  out  32  to register file write data.
- wb_regAddr  out  5  to register file write address.
- wb_regWrite  out  1  to register file write enable.
- rLLbit  out  1  forwarded LLbit to MEM (combinational).
- retired  out  32  count of valid instructions that entered WB.

## Operation
- State: pipeline register {data, addr, we, llwe, llval, valid}; LLbit register `llbit`; counter `retired`.
- Qualification: LLbit write request captured as `llwe = wbit & mem_valid`; `regWrite` captured as `regWrite & mem_valid`.
- Per rising edge, priority order:
  1. rst=1: all pipeline fields, `llbit`, `retired` <= 0.
  2. flush=1: pipeline fields <= 0 (bubble); `llbit` <= 0; `retired` unchanged. Flush overrides stalls and any pending LLbit write.
  3. stall_mem=1, stall_wb=0: insert bubble (pipeline fields <= 0).
  4. stall_mem=1, stall_wb=1: hold all pipeline fields.
  5. stall_mem=0, stall_wb=1: illegal controller combination; hold (same as 4).
  6. otherwise: capture MEM inputs.
- LLbit commit: on every non-reset, non-flush edge where the registered `llwe`=1 and stall_wb=0, `llbit` <= registered `llval`. Under stall_wb=1 the commit is deferred (entry held, commits once released; it must commit exactly once).
- Forwarding: rLLbit = flush ? 0 : (registered llwe ? registered llval : llbit). MEM therefore sees an `ll` one instruction ahead, making back-to-back `ll`; `sc` succeed.
- Counter: `retired` += 1 on edges where case 6 applies and mem_valid=1; wraps modulo 2^32 (0xFFFFFFFF -> 0).
- Outputs wb_* are direct register outputs; no combinational path from MEM inputs to wb_*.

## Timing
- Latency: MEM inputs visible on wb_* one cycle after the capturing edge.
- rLLbit: zero-latency combinational from flush and registered state; no path from regData/regAddr/regWrite.
- Reset values: wb_regData=0, wb_regAddr=0, wb_regWrite=0, rLLbit=0, retired=0.
- Reset asserted mid-stall or with pending LLbit write: everything cleared that edge; pending write lost.
- Simultaneous flush and captured `ll` in MEM: `ll` discarded, llbit=0.
- Simultaneous LLbit commit of older entry and new capture: commit uses the old registered entry; new entry replaces it in the same edge.

## Test plan
- Reset: hold rst=1 two cycles with random inputs -> all outputs 0; release, regData=0x12345678, regAddr=5, regWrite=1, mem_valid=1 -> next cycle wb_regData=0x12345678, wb_regAddr=5, wb_regWrite=1, retired=1.
- LL/SC forwarding: `ll` cycle (wbit=1, wLLbit=1) then `sc` cycle -> rLLbit=1 during `sc` cycle (forwarded), llbit=1 after commit; `sc` cycle with wbit=1, wLLbit=0 -> rLLbit=0 the cycle after.
- Flush: llbit=1, assert flush -> rLLbit=0 same cycle; next cycle wb_regWrite=0, llbit=0, retired unchanged.
- Stalls: stall_mem=1, stall_wb=0 -> next wb_regWrite=0 (bubble); both stalls with pending `ll` entry -> wb_* held 3 cycles, llbit commits once after release.
- Bubble qualification: mem_valid=0, regWrite=1, wbit=1 -> wb_regWrite=0, llbit unchanged, retired unchanged.
- Counter wrap: force retired=0xFFFFFFFF, one valid capture -> retired=0.
